// File: rtl/datapath_fetch_pipe.sv
// Instruction-fetch stage: PC, one-cycle synchronous imem request, stall hold buffer, IF/ID register.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined; otherwise perf ports read 0.
module datapath_fetch_pipe #(
  parameter int                    PC_WIDTH    = 16,
  parameter int                    INSTR_WIDTH = 16,
  parameter int                    PC_INC      = 2,
  parameter logic [PC_WIDTH-1:0]   RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PC_WIDTH-1:0]    BT,
  input  logic                   branch_taken,
  input  logic                   stall,
  output logic [PC_WIDTH-1:0]    mem_addr,
  output logic                   mem_rd,
  input  logic [INSTR_WIDTH-1:0] mem_rddata,
  output logic                   if_id_valid,
  output logic [INSTR_WIDTH-1:0] if_id_instr,
  output logic [PC_WIDTH-1:0]    if_id_pc,
  output logic [PC_WIDTH-1:0]    if_id_pc_next,
  output logic [31:0]            perf_fetched,
  output logic [31:0]            perf_bubbles
);

  localparam logic [PC_WIDTH-1:0] PC_INC_W   = PC_WIDTH'(PC_INC);
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~(PC_INC_W - PC_WIDTH'(1));

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_STALL    = 2'd1,
    MODE_REDIRECT = 2'd2
  } cycle_mode_e;

  cycle_mode_e mode;

  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic                   req_valid_q, req_valid_d;
  logic [PC_WIDTH-1:0]    req_pc_q, req_pc_d;
  logic                   hold_valid_q, hold_valid_d;
  logic [INSTR_WIDTH-1:0] hold_instr_q, hold_instr_d;
  logic [PC_WIDTH-1:0]    hold_pc_q, hold_pc_d;
  logic                   if_id_valid_q, if_id_valid_d;
  logic [INSTR_WIDTH-1:0] if_id_instr_q, if_id_instr_d;
  logic [PC_WIDTH-1:0]    if_id_pc_q, if_id_pc_d;
  logic [PC_WIDTH-1:0]    if_id_pc_next_q, if_id_pc_next_d;
  logic                   fetch_edge;

  // Memory handshake: mem_rd=1 in a cycle is a read of mem_addr; mem_rddata carries that word
  // during the following cycle only. There is no back-pressure, so a response the IF/ID
  // cannot take (stall) is parked in the hold buffer.
  always_comb begin
    mode = MODE_RUN;
    if (branch_taken)  mode = MODE_REDIRECT;
    else if (stall)    mode = MODE_STALL;
  end

  assign mem_addr = pc_q;
  assign mem_rd   = !stall && !branch_taken && reset;

  always_comb begin
    pc_d            = pc_q;
    req_valid_d     = req_valid_q;
    req_pc_d        = req_pc_q;
    hold_valid_d    = hold_valid_q;
    hold_instr_d    = hold_instr_q;
    hold_pc_d       = hold_pc_q;
    if_id_valid_d   = if_id_valid_q;
    if_id_instr_d   = if_id_instr_q;
    if_id_pc_d      = if_id_pc_q;
    if_id_pc_next_d = if_id_pc_next_q;
    fetch_edge      = 1'b0;
    unique case (mode)
      MODE_REDIRECT: begin
        pc_d          = BT & ALIGN_MASK;
        req_valid_d   = 1'b0;
        hold_valid_d  = 1'b0;
        if_id_valid_d = 1'b0;
      end
      MODE_STALL: begin
        req_valid_d = 1'b0;
        if (req_valid_q) begin
          hold_valid_d = 1'b1;
          hold_instr_d = mem_rddata;
          hold_pc_d    = req_pc_q;
        end
      end
      default: begin
        pc_d        = pc_q + PC_INC_W;
        req_valid_d = 1'b1;
        req_pc_d    = pc_q;
        // The hold buffer is older than any in-flight request, so it drains first.
        if (hold_valid_q) begin
          fetch_edge      = 1'b1;
          hold_valid_d    = 1'b0;
          if_id_valid_d   = 1'b1;
          if_id_instr_d   = hold_instr_q;
          if_id_pc_d      = hold_pc_q;
          if_id_pc_next_d = hold_pc_q + PC_INC_W;
        end else if (req_valid_q) begin
          fetch_edge      = 1'b1;
          if_id_valid_d   = 1'b1;
          if_id_instr_d   = mem_rddata;
          if_id_pc_d      = req_pc_q;
          if_id_pc_next_d = req_pc_q + PC_INC_W;
        end else begin
          if_id_valid_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q            <= RESET_PC;
      req_valid_q     <= 1'b0;
      req_pc_q        <= '0;
      hold_valid_q    <= 1'b0;
      hold_instr_q    <= '0;
      hold_pc_q       <= '0;
      if_id_valid_q   <= 1'b0;
      if_id_instr_q   <= '0;
      if_id_pc_q      <= '0;
      if_id_pc_next_q <= '0;
    end else begin
      pc_q            <= pc_d;
      req_valid_q     <= req_valid_d;
      req_pc_q        <= req_pc_d;
      hold_valid_q    <= hold_valid_d;
      hold_instr_q    <= hold_instr_d;
      hold_pc_q       <= hold_pc_d;
      if_id_valid_q   <= if_id_valid_d;
      if_id_instr_q   <= if_id_instr_d;
      if_id_pc_q      <= if_id_pc_d;
      if_id_pc_next_q <= if_id_pc_next_d;
    end
  end

  assign if_id_valid   = if_id_valid_q;
  assign if_id_instr   = if_id_instr_q;
  assign if_id_pc      = if_id_pc_q;
  assign if_id_pc_next = if_id_pc_next_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_bubbles_q, perf_bubbles_d;

  // Every edge is exactly one of: a valid IF/ID load, or a bubble/held edge.
  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_bubbles_d = perf_bubbles_q;
    if (fetch_edge) perf_fetched_d = perf_fetched_q + 32'd1;
    else            perf_bubbles_d = perf_bubbles_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched_q <= '0;
      perf_bubbles_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_bubbles_q <= perf_bubbles_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_bubbles = perf_bubbles_q;
`else
  logic unused_perf;
  assign unused_perf  = fetch_edge;
  assign perf_fetched = '0;
  assign perf_bubbles = '0;
`endif

endmodule

// File: tb/tb_datapath_fetch_pipe.sv
// Bench for datapath_fetch_pipe: two instances (RESET_PC 0x0000 and 0xFFFC) under shared stimulus,
// compared every cycle against a two-slot pipeline model where a stall simply freezes the pipe.
module tb_datapath_fetch_pipe;
  localparam int PW  = 16;
  localparam int IW  = 16;
  localparam int INC = 2;
`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          stall = 1'b0;
  logic          branch_taken = 1'b0;
  logic [PW-1:0] bt = '0;

  logic [1:0][PW-1:0] mem_addr, if_id_pc, if_id_pc_next;
  logic [1:0]         mem_rd, if_id_valid;
  logic [1:0][IW-1:0] mem_rddata, if_id_instr;
  logic [1:0][31:0]   perf_fetched, perf_bubbles;

  int total = 0;
  int bad   = 0;

  // model state: pc, one in-flight slot, IF/ID, counters
  logic [PW-1:0] rst_pc [2];
  logic [PW-1:0] m_pc [2];
  bit            m_slot_v [2];
  logic [PW-1:0] m_slot_pc [2];
  bit            m_ifid_v [2];
  logic [PW-1:0] m_ifid_pc [2];
  logic [31:0]   m_fetched [2];
  logic [31:0]   m_bubbles [2];

  always #5 clk = ~clk;

  datapath_fetch_pipe #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .PC_INC(INC), .RESET_PC(16'h0000)) u_dut0 (
    .clk(clk), .reset(reset), .BT(bt), .branch_taken(branch_taken), .stall(stall),
    .mem_addr(mem_addr[0]), .mem_rd(mem_rd[0]), .mem_rddata(mem_rddata[0]),
    .if_id_valid(if_id_valid[0]), .if_id_instr(if_id_instr[0]), .if_id_pc(if_id_pc[0]),
    .if_id_pc_next(if_id_pc_next[0]), .perf_fetched(perf_fetched[0]), .perf_bubbles(perf_bubbles[0])
  );

  datapath_fetch_pipe #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .PC_INC(INC), .RESET_PC(16'hFFFC)) u_dut1 (
    .clk(clk), .reset(reset), .BT(bt), .branch_taken(branch_taken), .stall(stall),
    .mem_addr(mem_addr[1]), .mem_rd(mem_rd[1]), .mem_rddata(mem_rddata[1]),
    .if_id_valid(if_id_valid[1]), .if_id_instr(if_id_instr[1]), .if_id_pc(if_id_pc[1]),
    .if_id_pc_next(if_id_pc_next[1]), .perf_fetched(perf_fetched[1]), .perf_bubbles(perf_bubbles[1])
  );

  function automatic logic [IW-1:0] mem_word(input logic [PW-1:0] a);
    return {a[7:0] ^ 8'h5A, a[15:8] ^ 8'hC3};
  endfunction

  // Synchronous imem; unrequested cycles return noise so stale data cannot pass unnoticed.
  always @(posedge clk) begin
    mem_rddata[0] <= mem_rd[0] ? mem_word(mem_addr[0]) : IW'($urandom);
    mem_rddata[1] <= mem_rd[1] ? mem_word(mem_addr[1]) : IW'($urandom);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pc[k]      = rst_pc[k];
      m_slot_v[k]  = 1'b0;
      m_slot_pc[k] = '0;
      m_ifid_v[k]  = 1'b0;
      m_ifid_pc[k] = '0;
      m_fetched[k] = '0;
      m_bubbles[k] = '0;
    end
  endtask

  task automatic model_edge(input bit s, input bit b, input logic [PW-1:0] t);
    for (int k = 0; k < 2; k++) begin
      if (b) begin
        m_pc[k]     = PW'((t / INC) * INC);
        m_slot_v[k] = 1'b0;
        m_ifid_v[k] = 1'b0;
        m_bubbles[k]++;
      end else if (s) begin
        m_bubbles[k]++;
      end else begin
        m_ifid_v[k] = m_slot_v[k];
        if (m_slot_v[k]) begin
          m_ifid_pc[k] = m_slot_pc[k];
          m_fetched[k]++;
        end else begin
          m_bubbles[k]++;
        end
        m_slot_v[k]  = 1'b1;
        m_slot_pc[k] = m_pc[k];
        m_pc[k]      = PW'(m_pc[k] + INC);
      end
    end
  endtask

  task automatic check_comb();
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("mem_rd[%0d]", k), 64'(mem_rd[k]), 64'(!stall && !branch_taken && reset));
      check_eq($sformatf("mem_addr[%0d]", k), 64'(mem_addr[k]), 64'(m_pc[k]));
    end
  endtask

  task automatic check_regs();
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("valid[%0d]", k), 64'(if_id_valid[k]), 64'(m_ifid_v[k]));
      if (m_ifid_v[k]) begin
        check_eq($sformatf("pc[%0d]", k), 64'(if_id_pc[k]), 64'(m_ifid_pc[k]));
        check_eq($sformatf("pc_next[%0d]", k), 64'(if_id_pc_next[k]), 64'(PW'(m_ifid_pc[k] + INC)));
        check_eq($sformatf("instr[%0d]", k), 64'(if_id_instr[k]), 64'(mem_word(m_ifid_pc[k])));
      end
      check_eq($sformatf("perf_fetched[%0d]", k), 64'(perf_fetched[k]), PERF_EN ? 64'(m_fetched[k]) : 64'd0);
      check_eq($sformatf("perf_bubbles[%0d]", k), 64'(perf_bubbles[k]), PERF_EN ? 64'(m_bubbles[k]) : 64'd0);
    end
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic step(input bit s, input bit b, input logic [PW-1:0] t);
    stall = s;
    branch_taken = b;
    bt = t;
    #1;
    check_comb();
    @(posedge clk);
    model_edge(s, b, t);
    #1;
    check_regs();
  endtask

  task automatic check_reset_state(input string tag);
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("%s_valid[%0d]", tag, k), 64'(if_id_valid[k]), 64'd0);
      check_eq($sformatf("%s_addr[%0d]", tag, k), 64'(mem_addr[k]), 64'(rst_pc[k]));
      check_eq($sformatf("%s_rd[%0d]", tag, k), 64'(mem_rd[k]), 64'd0);
      check_eq($sformatf("%s_pf[%0d]", tag, k), 64'(perf_fetched[k]), 64'd0);
      check_eq($sformatf("%s_pb[%0d]", tag, k), 64'(perf_bubbles[k]), 64'd0);
    end
  endtask

  // Asserts reset between edges and checks the outputs before any clock edge arrives.
  task automatic async_reset(input string tag);
    #2;
    reset = 1'b0;
    #1;
    check_reset_state(tag);
    model_reset();
    @(posedge clk);
    #1;
    check_regs();
    stall = 1'b0;
    branch_taken = 1'b0;
    reset = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_pc[0] = 16'h0000;
    rst_pc[1] = 16'hFFFC;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("cold");
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("cold_instr[%0d]", k), 64'(if_id_instr[k]), 64'd0);
      check_eq($sformatf("cold_pc[%0d]", k), 64'(if_id_pc[k]), 64'd0);
      check_eq($sformatf("cold_pc_next[%0d]", k), 64'(if_id_pc_next[k]), 64'd0);
    end
    reset = 1'b1;

    // sequential fetch and wrap
    step(0, 0, '0);
    check_eq("first_edge_invalid", 64'(if_id_valid[0]), 64'd0);
    step(0, 0, '0);
    check_eq("seq_pc0", 64'(if_id_pc[0]), 64'h0000);
    check_eq("wrap_pc0", 64'(if_id_pc[1]), 64'hFFFC);
    step(0, 0, '0);
    check_eq("seq_pc1", 64'(if_id_pc[0]), 64'h0002);
    check_eq("wrap_pc1", 64'(if_id_pc[1]), 64'hFFFE);
    check_eq("wrap_pc_next", 64'(if_id_pc_next[1]), 64'h0000);
    step(0, 0, '0);
    check_eq("seq_pc2", 64'(if_id_pc[0]), 64'h0004);
    check_eq("wrap_pc2", 64'(if_id_pc[1]), 64'h0000);

    // 3-cycle stall mid-stream
    for (int i = 0; i < 3; i++) begin
      step(1, 0, '0);
      check_eq("stall_frozen", 64'(if_id_pc[0]), 64'h0004);
    end
    step(0, 0, '0);
    check_eq("stall_resume0", 64'(if_id_pc[0]), 64'h0006);
    check_eq("stall_resume_instr", 64'(if_id_instr[0]), 64'(mem_word(16'h0006)));
    step(0, 0, '0);
    check_eq("stall_resume1", 64'(if_id_pc[0]), 64'h0008);

    // redirect to an unaligned target
    step(0, 1, 16'h0041);
    check_eq("redir_e0_valid", 64'(if_id_valid[0]), 64'd0);
    check_eq("redir_mem_addr", 64'(mem_addr[0]), 64'h0040);
    step(0, 0, '0);
    check_eq("redir_e1_valid", 64'(if_id_valid[0]), 64'd0);
    step(0, 0, '0);
    check_eq("redir_target_pc", 64'(if_id_pc[0]), 64'h0040);
    check_eq("redir_target_valid", 64'(if_id_valid[0]), 64'd1);

    // stall + redirect together, with the hold buffer loaded first
    step(0, 0, '0);
    step(1, 0, '0);
    step(1, 1, 16'h0041);
    check_eq("sb_e0_valid", 64'(if_id_valid[0]), 64'd0);
    step(0, 0, '0);
    check_eq("sb_e1_valid", 64'(if_id_valid[0]), 64'd0);
    step(0, 0, '0);
    check_eq("sb_target_pc", 64'(if_id_pc[0]), 64'h0040);

    // async reset in the middle of a stall with pending held data
    step(0, 0, '0);
    step(1, 0, '0);
    stall = 1'b1;
    async_reset("midstall");
    for (int i = 0; i < 4; i++) step(0, 0, '0);

    // randomized traffic with occasional async resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        stall = 1'($urandom_range(0, 1));
        branch_taken = 1'($urandom_range(0, 1));
        async_reset("rand_rst");
      end else begin
        step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, PW'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
